mat_operand_loader: RTL and testbench
=====================================

Name: mat_operand_loader

Overview:
- Producer side of the packed-operand interface used by multple_mat.
- Takes a byte-serial stream of matrix elements and assembles them into the two 32-bit operand words A and B, each holding four 8-bit elements.
- Presents each complete A/B pair to the multiplier with a valid/ready handshake.
- Double-buffered: one pair can assemble while the previous pair waits to be consumed.

Parameters:
- WIDTH, 32, operand word width; fixed at 4 elements x 8 bits. Other values are unsupported; elaboration fails via a generate-time check.
- CNT_W, 16, width of the issued-pair counter.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- in_data  input  8  matrix element.
- in_valid  input  1  in_data valid.
- in_first  input  1  marks element 0 of a pair; qualified by in_valid.
- in_ready  output  1  element accepted when in_valid && in_ready.
- A_out  output  WIDTH  packed operand A.
- B_out  output  WIDTH  packed operand B.
- out_valid  output  1  A_out/B_out hold a complete pair.
- out_ready  input  1  consumer takes the pair when out_valid && out_ready.
- frame_err  output  1  one-cycle pulse on resynchronisation.
- pair_cnt  output  CNT_W  number of pairs handed off; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset==0 at a posedge):
  - Clears idx, the assembly register, the pending flag, A_out, B_out, out_valid, frame_err and pair_cnt.
  - in_ready returns to 1.
  - Applies mid-pair and mid-handshake; any partial or pending pair is discarded.
- Element placement, for accepted element index k = 0..7:
  - k = 0..3 → A byte at bits [31-8k : 24-8k].
  - k = 4..7 → B byte at bits [31-8(k-4) : 24-8(k-4)].
  - Element 0 is the MSB. Example: a00 a01 a10 a11 → A = {a00,a01,a10,a11}.
- States:
  - FILL: idx 0..7, in_ready = 1.
  - PEND: complete pair held in the assembly register, in_ready = 0.
  - in_ready is driven from registered state only; there is no combinational path from out_ready.
- Completion, on the edge where element k = 7 is accepted:
  - If out_valid == 0, or out_valid && out_ready that cycle: load A_out/B_out with the full pair, out_valid = 1, pair_cnt += 1, idx = 0, stay in FILL.
  - Otherwise: go to PEND.
  - Latency: last element accepted at edge N → out_valid high from edge N onward, visible in cycle N+1.
- PEND: when out_valid && out_ready, the pending pair moves to A_out/B_out at that edge, out_valid stays 1, pair_cnt += 1, state returns to FILL with idx = 0.
- Output handshake:
  - If out_valid && out_ready and there is no new or pending pair: out_valid = 0.
  - A_out/B_out keep their last value (they are not cleared).
  - A_out/B_out are stable whenever out_valid == 1 && out_ready == 0.
- in_first:
  - Accepted with in_first == 1 at idx != 0: partial pair discarded, element stored as k = 0, idx = 1, frame_err = 1 for exactly one cycle.
  - At idx == 0: no effect.
  - in_first is not required to start a pair.
- Simultaneous events:
  - Completion and output handshake in the same cycle → new pair loaded with no bubble; out_valid stays 1.
- pair_cnt wraps from 2^CNT_W−1 to 0 with no flag.

Optional Feature:
- MAT_LOAD_TRANSPOSE_B_EN.
- Defined: B elements arrive column-major (b00 b10 b01 b11) and are stored row-major. Element k = 4..7 maps to B positions 0, 2, 1, 3 respectively.
- Undefined: B is stored in arrival order, identical to A.
- A is never affected by the macro.

Test Plan:
- Identity load: bytes 01 00 00 01 01 02 03 04 with out_ready = 1 → one cycle after the last byte, out_valid = 1, A_out = 32'h01000001, B_out = 32'h01020304, pair_cnt = 1. With MAT_LOAD_TRANSPOSE_B_EN, B_out = 32'h01030204.
- Backpressure: out_ready = 0, stream 3 pairs back to back:
  - in_ready drops after the 16th byte; the 17th byte is held with no loss.
  - Raise out_ready for 1 cycle → A_out/B_out switch to pair 2 and in_ready = 1 the next cycle.
  - Final pair_cnt after all drained = 3.
- Resync: send 3 bytes, then 8 bytes with the first flagged in_first = 1 → frame_err pulses once; output pair equals the last 8 bytes only.
- Zero-bubble: out_ready held 1, continuous in_valid → out_valid stays high across the transition, a new pair every 8 cycles.
- Reset mid-operation: 5 bytes accepted plus one pair pending, then reset = 0 for 1 cycle → out_valid = 0, pair_cnt = 0, in_ready = 1; the next 8 bytes form a clean pair.
- Wrap: CNT_W = 2, issue 5 pairs → pair_cnt reads 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/mat_operand_loader.sv
// mat_operand_loader: assembles a byte-serial element stream into packed
// 32-bit operand words A and B (four 8-bit elements each, element 0 in the
// MSB) and hands each A/B pair off with a valid/ready handshake.
// A second pair can assemble while the previous one waits at the output;
// a completed pair that cannot be handed off is parked in the PEND state.
// Optional build macro: MAT_LOAD_TRANSPOSE_B_EN -- B elements arrive
// column-major and are stored row-major (arrival 4..7 -> B slots 0,2,1,3).
module mat_operand_loader #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_first,
  output logic             in_ready,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic [CNT_W-1:0] pair_cnt
);

  // Operand layout is hard-wired to four 8-bit elements per word.
  generate
    if (WIDTH != 32) begin : g_width_check
      $error("mat_operand_loader: WIDTH must be 32 (4 x 8-bit elements)");
    end
  endgenerate

  typedef enum logic {
    ST_FILL,
    ST_PEND
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [2*WIDTH-1:0]   asm_q, asm_d;
  logic [WIDTH-1:0]     a_out_q, a_out_d;
  logic [WIDTH-1:0]     b_out_q, b_out_d;
  logic                 out_valid_q, out_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic [CNT_W-1:0]     pair_cnt_q, pair_cnt_d;

  logic                 take;
  logic [2:0]           k;
  logic [2:0]           pos;

  // Input side is open only while no completed pair is parked.
  assign in_ready  = (state_q == ST_FILL);
  assign A_out     = a_out_q;
  assign B_out     = b_out_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign pair_cnt  = pair_cnt_q;

  // Next-state: element placement, resync, completion and output handoff.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    a_out_d     = a_out_q;
    b_out_d     = b_out_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;
    pair_cnt_d  = pair_cnt_q;
    k           = idx_q;
    pos         = idx_q;

    take = out_valid_q && out_ready;
    if (take) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          // in_first mid-pair restarts assembly with this element as k = 0.
          if (in_first && (idx_q != 3'd0)) begin
            asm_d       = '0;
            k           = 3'd0;
            frame_err_d = 1'b1;
          end
          pos = k;
`ifdef MAT_LOAD_TRANSPOSE_B_EN
          // Column-major B arrival: swapping the two low index bits maps
          // arrival 4,5,6,7 onto row-major slots 4,6,5,7.
          if (k[2]) begin
            pos = {1'b1, k[0], k[1]};
          end
`endif
          for (int unsigned p = 0; p < 8; p++) begin
            if (3'(p) == pos) begin
              asm_d[8*(7-p) +: 8] = in_data;
            end
          end

          if (k == 3'd7) begin
            idx_d = 3'd0;
            if (!out_valid_q || take) begin
              a_out_d     = asm_d[2*WIDTH-1:WIDTH];
              b_out_d     = asm_d[WIDTH-1:0];
              out_valid_d = 1'b1;
              pair_cnt_d  = pair_cnt_q + CNT_W'(1);
            end else begin
              state_d = ST_PEND;
            end
          end else begin
            idx_d = k + 3'd1;
          end
        end
      end

      ST_PEND: begin
        if (take) begin
          a_out_d     = asm_q[2*WIDTH-1:WIDTH];
          b_out_d     = asm_q[WIDTH-1:0];
          out_valid_d = 1'b1;
          pair_cnt_d  = pair_cnt_q + CNT_W'(1);
          state_d     = ST_FILL;
          idx_d       = 3'd0;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_FILL;
      idx_q       <= '0;
      asm_q       <= '0;
      a_out_q     <= '0;
      b_out_q     <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      pair_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      pair_cnt_q  <= pair_cnt_d;
    end
  end

endmodule

// File: tb/tb_mat_operand_loader.sv
// Bench for mat_operand_loader: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model. A second
// instance with a 2-bit pair counter exercises counter wrap.
module tb_mat_operand_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, frame_err;
  logic [31:0] A_out, B_out;
  logic [15:0] pair_cnt;

  logic        in_ready2, out_valid2, frame_err2;
  logic [31:0] a_out2, b_out2;
  logic [1:0]  pair_cnt2;

  always #5 clk = ~clk;

  mat_operand_loader #(.WIDTH(32), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_first(in_first), .in_ready(in_ready), .A_out(A_out), .B_out(B_out),
    .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err),
    .pair_cnt(pair_cnt)
  );

  mat_operand_loader #(.WIDTH(32), .CNT_W(2)) u_dut_wrap (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_first(in_first), .in_ready(in_ready2), .A_out(a_out2), .B_out(b_out2),
    .out_valid(out_valid2), .out_ready(out_ready), .frame_err(frame_err2),
    .pair_cnt(pair_cnt2)
  );

  // Reference model: list of elements of the pair being assembled, a queue of
  // completed pairs waiting for the output slot, and the output slot itself.
  logic [7:0]  elems[$];
  logic [63:0] pend[$];
  logic [31:0] m_a = '0, m_b = '0;
  logic        m_ov = 1'b0, m_fe = 1'b0, m_acc = 1'b0;
  int unsigned m_cnt = 0;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  function automatic logic [63:0] build_pair();
    logic [7:0] e[8];
    for (int i = 0; i < 8; i++) e[i] = elems[i];
`ifdef MAT_LOAD_TRANSPOSE_B_EN
    return {e[0], e[1], e[2], e[3], e[4], e[6], e[5], e[7]};
`else
    return {e[0], e[1], e[2], e[3], e[4], e[5], e[6], e[7]};
`endif
  endfunction

  task automatic model_step(input logic v, input logic f, input logic [7:0] d,
                            input logic ordy, input logic rst);
    logic        ready, take, ov0;
    logic [63:0] pr;
    m_acc = 1'b0;
    if (!rst) begin
      elems.delete();
      pend.delete();
      m_a = '0; m_b = '0; m_ov = 1'b0; m_fe = 1'b0; m_cnt = 0;
    end else begin
      ready = (pend.size() == 0);
      ov0   = m_ov;
      take  = m_ov && ordy;
      m_fe  = 1'b0;
      if (take) begin
        if (pend.size() != 0) begin
          pr = pend.pop_front();
          m_a = pr[63:32]; m_b = pr[31:0];
          m_cnt++;
        end else begin
          m_ov = 1'b0;
        end
      end
      if (v && ready) begin
        m_acc = 1'b1;
        if (f && elems.size() != 0) begin
          elems.delete();
          m_fe = 1'b1;
        end
        elems.push_back(d);
        if (elems.size() == 8) begin
          pr = build_pair();
          elems.delete();
          if (!ov0 || take) begin
            m_a = pr[63:32]; m_b = pr[31:0];
            m_ov = 1'b1;
            m_cnt++;
          end else begin
            pend.push_back(pr);
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic check_all();
    chk("in_ready",  {63'd0, in_ready},  {63'd0, pend.size() == 0});
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
    chk("A_out",     {32'd0, A_out},     {32'd0, m_a});
    chk("B_out",     {32'd0, B_out},     {32'd0, m_b});
    chk("frame_err", {63'd0, frame_err}, {63'd0, m_fe});
    chk("pair_cnt",  {48'd0, pair_cnt},  {48'd0, 16'(m_cnt)});
    chk("w_ready",   {63'd0, in_ready2}, {63'd0, pend.size() == 0});
    chk("w_valid",   {63'd0, out_valid2}, {63'd0, m_ov});
    chk("w_A",       {32'd0, a_out2},    {32'd0, m_a});
    chk("w_B",       {32'd0, b_out2},    {32'd0, m_b});
    chk("w_fe",      {63'd0, frame_err2}, {63'd0, m_fe});
    chk("w_cnt",     {62'd0, pair_cnt2}, {62'd0, 2'(m_cnt)});
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic cyc(input logic v, input logic f, input logic [7:0] d,
                     input logic ordy, input logic rst);
    in_valid = v; in_first = f; in_data = d; out_ready = ordy; reset = rst;
    model_step(v, f, d, ordy, rst);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  // Offer one element until accepted, with a bounded wait.
  task automatic send(input logic [7:0] d, input logic f, input logic ordy);
    int n = 0;
    do begin
      cyc(1'b1, f, d, ordy, 1'b1);
      n++;
    end while (!m_acc && n < 40);
    if (!m_acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  logic [31:0] exp_b_id, exp_b_rs;
  logic [1:0]  wrap_exp[5];

  initial begin
`ifdef MAT_LOAD_TRANSPOSE_B_EN
    exp_b_id = 32'h01030204;
    exp_b_rs = 32'h44464547;
`else
    exp_b_id = 32'h01020304;
    exp_b_rs = 32'h44454647;
`endif
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    @(negedge clk);
    // Reset state
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_cnt", {48'd0, pair_cnt}, 64'd0);

    // Identity load
    begin
      logic [7:0] id_bytes[8];
      id_bytes = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
      for (int i = 0; i < 8; i++) send(id_bytes[i], 1'b0, 1'b1);
    end
    chk("id_valid", {63'd0, out_valid}, 64'd1);
    chk("id_A", {32'd0, A_out}, {32'd0, 32'h01000001});
    chk("id_B", {32'd0, B_out}, {32'd0, exp_b_id});
    chk("id_cnt", {48'd0, pair_cnt}, 64'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("id_drained", {63'd0, out_valid}, 64'd0);

    // Backpressure: three pairs back to back with out_ready low
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 1'b0, 1'b0);
    chk("bp_ready_low", {63'd0, in_ready}, 64'd0);
    chk("bp_A_pair1", {32'd0, A_out}, {32'd0, 32'h10111213});
    cyc(1'b1, 1'b0, 8'h20, 1'b0, 1'b1);
    chk("bp_hold", {63'd0, in_ready}, 64'd0);
    cyc(1'b1, 1'b0, 8'h20, 1'b1, 1'b1);
    chk("bp_A_pair2", {32'd0, A_out}, {32'd0, 32'h18191a1b});
    chk("bp_B_pair2", {32'd0, B_out[31:24]}, 64'h1c);
    chk("bp_ready_back", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 8; i++) send(8'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("bp_A_pair3", {32'd0, A_out}, {32'd0, 32'h20212223});
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("bp_cnt", {48'd0, pair_cnt}, 64'd4);
    chk("bp_empty", {63'd0, out_valid}, 64'd0);

    // Resync: 3 stray bytes then a flagged 8-byte pair
    for (int i = 0; i < 3; i++) send(8'(8'hA0 + i), 1'b0, 1'b1);
    send(8'h40, 1'b1, 1'b1);
    chk("rs_fe_pulse", {63'd0, frame_err}, 64'd1);
    send(8'h41, 1'b0, 1'b1);
    chk("rs_fe_once", {63'd0, frame_err}, 64'd0);
    for (int i = 2; i < 8; i++) send(8'(8'h40 + i), 1'b0, 1'b1);
    chk("rs_A", {32'd0, A_out}, {32'd0, 32'h40414243});
    chk("rs_B", {32'd0, B_out}, {32'd0, exp_b_rs});
    chk("rs_cnt", {48'd0, pair_cnt}, 64'd5);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Zero-bubble: completion coincides with output handshake
    for (int i = 0; i < 8; i++) send(8'(8'h50 + i), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) send(8'(8'h60 + i), 1'b0, 1'b0);
    send(8'h67, 1'b0, 1'b1);
    chk("zb_valid", {63'd0, out_valid}, 64'd1);
    chk("zb_A", {32'd0, A_out}, {32'd0, 32'h60616263});
    chk("zb_cnt", {48'd0, pair_cnt}, 64'd7);
    for (int i = 0; i < 16; i++) send(8'(8'h70 + i), 1'b0, 1'b1);
    chk("zb_cnt2", {48'd0, pair_cnt}, 64'd9);

    // Reset mid-operation: output pair waiting and 5 bytes partly assembled
    for (int i = 0; i < 5; i++) send(8'(8'h90 + i), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("mr_valid", {63'd0, out_valid}, 64'd0);
    chk("mr_cnt", {48'd0, pair_cnt}, 64'd0);
    chk("mr_ready", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 8; i++) send(8'(8'hC0 + i), 1'b0, 1'b0);
    chk("mr_A", {32'd0, A_out}, {32'd0, 32'hC0C1C2C3});
    chk("mr_cnt1", {48'd0, pair_cnt}, 64'd1);

    // Counter wrap on the 2-bit instance
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 8; i++) send(8'($urandom), 1'b0, 1'b1);
      chk("wrap_cnt", {62'd0, pair_cnt2}, {62'd0, wrap_exp[p]});
    end

    // Random traffic with occasional resync and reset
    for (int n = 0; n < 3000; n++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
          8'($urandom), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 299) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
